// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the trainer CPU run/load controller:
//   - state_e     : controller state encoding (also driven out on state_o)
//   - DEF_*       : default parameter values
//   - cnt_w()     : width of a counter able to hold 0..depth inclusive
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam int DEF_PRESCALE_W = 26;
  localparam int DEF_PROG_DEPTH = 16;
  localparam int DEF_DATA_W     = 8;

  // load_count must represent the full value PROG_DEPTH, hence the +1.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Free-running PRESCALE_W-bit counter used to pace CPU ticks in RUN.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : force the count to zero (dominates en)
//   en       : advance the count by one this cycle
//   tc_o     : combinational terminal-count flag; high in the cycle the
//              counter sits at all-ones while enabled (it wraps to 0 next)
module tick_prescaler #(
  parameter int PRESCALE_W = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;  // natural wrap from all-ones to zero
    end
  end

  assign tc_o = en && !clr && (cnt_q == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run/load controller for the trainer CPU. Streams a program into the CPU
// instruction memory over a byte handshake (CPU held in reset meanwhile),
// then drives the CPU with a one-cycle clock enable produced either by the
// prescaler (RUN) or by step pulses (HALT). All outputs are registered.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   load_req          : level, request/continue a program load
//   byte_valid/_data  : offered program byte
//   byte_ready        : byte accepted this cycle when byte_valid is high
//   go, halt, step    : execution control pulses
//   cpu_rst           : CPU reset (high in IDLE and LOAD)
//   cpu_instr_we      : one-cycle instruction-memory write strobe
//   cpu_data          : instruction byte accompanying the strobe
//   cpu_tick          : one-cycle CPU clock enable
//   load_count        : bytes loaded since the last load start
//   state_o           : IDLE=0, LOAD=1, RUN=2, HALT=3
//   busy              : state_o != IDLE
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int PROG_DEPTH = DEF_PROG_DEPTH,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_req,
  input  logic                             byte_valid,
  input  logic [DATA_W-1:0]                byte_data,
  output logic                             byte_ready,
  input  logic                             go,
  input  logic                             halt,
  input  logic                             step,
  output logic                             cpu_rst,
  output logic                             cpu_instr_we,
  output logic [DATA_W-1:0]                cpu_data,
  output logic                             cpu_tick,
  output logic [cnt_w(PROG_DEPTH)-1:0]     load_count,
  output logic [1:0]                       state_o,
  output logic                             busy
);

  localparam int LC_W = cnt_w(PROG_DEPTH);
  localparam logic [LC_W-1:0] DEPTH_C = LC_W'(PROG_DEPTH);

  state_e            state_q, state_d;
  logic [LC_W-1:0]   load_count_q, load_count_d;
  logic              byte_ready_q, byte_ready_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              cpu_instr_we_q, cpu_instr_we_d;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
  logic              cpu_tick_q, cpu_tick_d;
  logic              busy_q, busy_d;

  logic transfer;
  logic clr_count;
  logic step_tick;
  logic presc_en;
  logic presc_tc;

  // The prescaler only counts while RUN persists; leaving RUN (or never
  // being in it) clears it, so every RUN entry restarts from zero and a
  // halt coinciding with terminal count produces no stray tick.
  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (!presc_en),
    .en   (presc_en),
    .tc_o (presc_tc)
  );

  always_comb begin
    state_d   = state_q;
    clr_count = 1'b0;
    transfer  = (state_q == ST_LOAD) && byte_valid && byte_ready_q;

    unique case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          state_d   = ST_LOAD;
          clr_count = 1'b1;
        end else if (go && (load_count_q != '0)) begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        // A transfer in the exit cycle still completes; see cpu_instr_we_d.
        if (!load_req) state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (halt) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (load_req) begin
          state_d   = ST_LOAD;
          clr_count = 1'b1;
        end else if (go) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    load_count_d = load_count_q;
    if (clr_count) begin
      load_count_d = '0;
    end else if (transfer) begin
      load_count_d = load_count_q + 1'b1;
    end

    // Ready is registered, so it is computed from the next-cycle count.
    byte_ready_d   = (state_d == ST_LOAD) && (load_count_d < DEPTH_C);
    cpu_instr_we_d = transfer;
    cpu_data_d     = transfer ? byte_data : cpu_data_q;
    cpu_rst_d      = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    busy_d         = (state_d != ST_IDLE);

    presc_en   = (state_q == ST_RUN) && (state_d == ST_RUN);
    // Steps only count while HALT is retained; go/load_req take priority.
    step_tick  = (state_q == ST_HALT) && (state_d == ST_HALT) && step;
    cpu_tick_d = presc_tc || step_tick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      load_count_q   <= '0;
      byte_ready_q   <= 1'b0;
      cpu_rst_q      <= 1'b1;
      cpu_instr_we_q <= 1'b0;
      cpu_data_q     <= '0;
      cpu_tick_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_count_q   <= load_count_d;
      byte_ready_q   <= byte_ready_d;
      cpu_rst_q      <= cpu_rst_d;
      cpu_instr_we_q <= cpu_instr_we_d;
      cpu_data_q     <= cpu_data_d;
      cpu_tick_q     <= cpu_tick_d;
      busy_q         <= busy_d;
    end
  end

  assign state_o      = state_q;
  assign load_count   = load_count_q;
  assign byte_ready   = byte_ready_q;
  assign cpu_rst      = cpu_rst_q;
  assign cpu_instr_we = cpu_instr_we_q;
  assign cpu_data     = cpu_data_q;
  assign cpu_tick     = cpu_tick_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl
// Directed bench for cpu_run_ctrl with PRESCALE_W=3 (tick every 8 cycles)
// and PROG_DEPTH=4. Inputs change 1 time unit after the rising edge and
// outputs are sampled at that same point, i.e. they show the result of the
// edge just taken.
module tb_cpu_run_ctrl;

  localparam int PRESCALE_W = 3;
  localparam int PROG_DEPTH = 4;
  localparam int DATA_W     = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_req, byte_valid, go, halt, step;
  logic [DATA_W-1:0] byte_data;
  logic              byte_ready, cpu_rst, cpu_instr_we, cpu_tick, busy;
  logic [DATA_W-1:0] cpu_data;
  logic [2:0]        load_count;
  logic [1:0]        state_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .PRESCALE_W(PRESCALE_W),
    .PROG_DEPTH(PROG_DEPTH),
    .DATA_W    (DATA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_req     (load_req),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .go           (go),
    .halt         (halt),
    .step         (step),
    .cpu_rst      (cpu_rst),
    .cpu_instr_we (cpu_instr_we),
    .cpu_data     (cpu_data),
    .cpu_tick     (cpu_tick),
    .load_count   (load_count),
    .state_o      (state_o),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int strobes;
  int ticks;
  int first_tick;

  initial begin
    rst = 1'b1; load_req = 1'b0; byte_valid = 1'b0; byte_data = '0;
    go = 1'b0; halt = 1'b0; step = 1'b0;
    #1;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    check("rst_state",  state_o, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_tick",   cpu_tick, 0);
    check("rst_we",     cpu_instr_we, 0);
    check("rst_ready",  byte_ready, 0);
    check("rst_count",  load_count, 0);
    check("rst_busy",   busy, 0);

    // go with an empty program is ignored
    go = 1'b1; cyc(); go = 1'b0;
    check("go_empty_state", state_o, 0);

    // Load three bytes back to back
    load_req = 1'b1; cyc();
    check("load_state", state_o, 1);
    check("load_ready", byte_ready, 1);
    check("load_busy",  busy, 1);
    byte_valid = 1'b1; byte_data = 8'hA1; cyc();
    check("ld0_we", cpu_instr_we, 1); check("ld0_data", cpu_data, 8'hA1); check("ld0_cnt", load_count, 1);
    byte_data = 8'h02; cyc();
    check("ld1_we", cpu_instr_we, 1); check("ld1_data", cpu_data, 8'h02); check("ld1_cnt", load_count, 2);
    byte_data = 8'h33; cyc();
    check("ld2_we", cpu_instr_we, 1); check("ld2_data", cpu_data, 8'h33); check("ld2_cnt", load_count, 3);
    byte_valid = 1'b0; cyc();
    check("ld_we_off", cpu_instr_we, 0);
    check("ld_cnt3",   load_count, 3);
    check("ld_ready3", byte_ready, 1);
    load_req = 1'b0; cyc();
    check("ld_exit_state", state_o, 0);
    check("ld_exit_rst",   cpu_rst, 1);

    // Overflow: six bytes offered, depth four
    load_req = 1'b1; cyc();
    check("ov_cnt_clr", load_count, 0);
    strobes = 0;
    byte_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      byte_data = 8'h10 + 8'(i);
      cyc();
      if (cpu_instr_we) strobes++;
    end
    check("ov_strobes", strobes, 4);
    check("ov_count",   load_count, 4);
    check("ov_ready",   byte_ready, 0);
    check("ov_data",    cpu_data, 8'h13);
    byte_valid = 1'b0; load_req = 1'b0; cyc();
    check("ov_exit_state", state_o, 0);

    // Two-byte load; second byte accepted in the same cycle load_req drops
    load_req = 1'b1; cyc();
    byte_valid = 1'b1; byte_data = 8'h55; cyc();
    byte_data = 8'h66; load_req = 1'b0; cyc();
    check("exit_xfer_state", state_o, 0);
    check("exit_xfer_we",    cpu_instr_we, 1);
    check("exit_xfer_data",  cpu_data, 8'h66);
    check("exit_xfer_cnt",   load_count, 2);
    byte_valid = 1'b0; cyc();
    check("exit_xfer_we_off", cpu_instr_we, 0);

    // RUN: ticks at 8, 16, 24 cycles after entry; load_req ignored
    go = 1'b1; cyc(); go = 1'b0;
    check("run_state",   state_o, 2);
    check("run_cpu_rst", cpu_rst, 0);
    load_req = 1'b1;
    ticks = 0; first_tick = -1;
    for (int i = 1; i <= 24; i++) begin
      cyc();
      if (cpu_tick) begin
        ticks++;
        if (first_tick < 0) first_tick = i;
      end
    end
    check("run_first_tick", first_tick, 8);
    check("run_ticks",      ticks, 3);
    check("run_ignore_ld",  state_o, 2);
    load_req = 1'b0;

    // Halt: no ticks for 20 cycles
    halt = 1'b1; cyc(); halt = 1'b0;
    check("halt_state", state_o, 3);
    check("halt_rst",   cpu_rst, 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (cpu_tick) ticks++;
    end
    check("halt_no_ticks", ticks, 0);

    // Two consecutive step pulses -> exactly two ticks
    ticks = 0;
    step = 1'b1; cyc(); if (cpu_tick) ticks++;
    cyc(); if (cpu_tick) ticks++;
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (cpu_tick) ticks++;
    end
    check("step_ticks", ticks, 2);

    // go + step together: RUN, no step tick, prescaler restarts at 0
    go = 1'b1; step = 1'b1; cyc(); go = 1'b0; step = 1'b0;
    check("gostep_state", state_o, 2);
    check("gostep_tick",  cpu_tick, 0);
    ticks = 0;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      if (cpu_tick) ticks++;
    end
    check("restart_quiet", ticks, 0);
    cyc();
    check("restart_tick8", cpu_tick, 1);

    // go + halt in RUN -> HALT
    go = 1'b1; halt = 1'b1; cyc(); go = 1'b0; halt = 1'b0;
    check("gohalt_state", state_o, 3);

    // load_req in HALT (with go) -> LOAD
    load_req = 1'b1; go = 1'b1; cyc(); go = 1'b0;
    check("haltld_state", state_o, 1);
    check("haltld_rst",   cpu_rst, 1);
    check("haltld_cnt",   load_count, 0);
    check("haltld_ready", byte_ready, 1);

    // Reset during LOAD after two bytes, with a transfer pending
    byte_valid = 1'b1; byte_data = 8'hAA; cyc();
    byte_data = 8'hBB; cyc();
    check("mid_cnt2", load_count, 2);
    rst = 1'b1; byte_data = 8'hCC; cyc();
    check("mid_rst_cnt",   load_count, 0);
    check("mid_rst_we",    cpu_instr_we, 0);
    check("mid_rst_state", state_o, 0);
    check("mid_rst_data",  cpu_data, 0);
    check("mid_rst_ready", byte_ready, 0);
    rst = 1'b0; byte_valid = 1'b0; load_req = 1'b0; cyc();
    check("post_rst_state", state_o, 0);
    check("post_rst_cpu",   cpu_rst, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
